// File: rtl/sdram_aref_ctrl.sv
// sdram_aref_ctrl: periodic auto-refresh requester and PRECHARGE/AUTO_REFRESH command sequencer
module sdram_aref_ctrl #(
    parameter int CNT_REF_MAX = 750,
    parameter int TRP_CLK     = 2,
    parameter int TRFC_CLK    = 7,
    parameter int AREF_NUM    = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_end_i,
    input  logic        aref_en_i,
    output logic        aref_req_o,
    output logic        aref_end_o,
    output logic [3:0]  aref_cmd_o,
    output logic [1:0]  aref_ba_o,
    output logic [12:0] aref_addr_o
);
    localparam int PMAX = TRP_CLK > TRFC_CLK ? TRP_CLK : TRFC_CLK;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int IW   = $clog2(CNT_REF_MAX);
    localparam int RW   = $clog2(AREF_NUM + 1);
    localparam logic [PW-1:0] TRP_LAST = PW'(TRP_CLK - 1);
    localparam logic [PW-1:0] TRF_LAST = PW'(TRFC_CLK - 1);
    localparam logic [IW-1:0] INT_LAST = IW'(CNT_REF_MAX - 1);
    localparam logic [RW-1:0] REF_NUM  = RW'(AREF_NUM);
    localparam logic [3:0]    CMD_NOP  = 4'b0111;
    localparam logic [3:0]    CMD_PRE  = 4'b0010;
    localparam logic [3:0]    CMD_REF  = 4'b0001;
    localparam logic [12:0]   ADDR_IDL = 13'h1fff;
    localparam logic [12:0]   ADDR_PRE = 13'h0400;
    typedef enum logic [2:0] {IDLE, PCHA, TRP, AREF, TRF, END} state_t;
    state_t        state;
    logic [IW-1:0] cnt_int;
    logic [PW-1:0] cnt_ph;
    logic [RW-1:0] cnt_ref;
    logic          wrap;
    logic          grant;
    assign wrap      = init_end_i && cnt_int == INT_LAST;
    assign grant     = state == IDLE && aref_en_i && aref_req_o;
    assign aref_ba_o = 2'b11;
    // a grant consumes the single pending request even on a coincident wrap
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || !init_end_i) begin
            cnt_int    <= '0;
            aref_req_o <= 1'b0;
        end else begin
            cnt_int    <= wrap ? '0 : cnt_int + 1'b1;
            aref_req_o <= grant ? 1'b0 : (wrap ? 1'b1 : aref_req_o);
        end
    end
    // outputs are registered alongside the state they belong to
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            cnt_ph      <= '0;
            cnt_ref     <= '0;
            aref_end_o  <= 1'b0;
            aref_cmd_o  <= CMD_NOP;
            aref_addr_o <= ADDR_IDL;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state       <= PCHA;
                    aref_cmd_o  <= CMD_PRE;
                    aref_addr_o <= ADDR_PRE;
                end
                PCHA: begin
                    state       <= TRP;
                    aref_cmd_o  <= CMD_NOP;
                    aref_addr_o <= ADDR_IDL;
                end
                TRP: if (cnt_ph == TRP_LAST) begin
                    state      <= AREF;
                    cnt_ph     <= '0;
                    aref_cmd_o <= CMD_REF;
                end else cnt_ph <= cnt_ph + 1'b1;
                AREF: begin
                    state      <= TRF;
                    cnt_ref    <= cnt_ref + 1'b1;
                    aref_cmd_o <= CMD_NOP;
                end
                TRF: if (cnt_ph == TRF_LAST) begin
                    cnt_ph     <= '0;
                    state      <= cnt_ref < REF_NUM ? AREF : END;
                    aref_cmd_o <= cnt_ref < REF_NUM ? CMD_REF : CMD_NOP;
                    aref_end_o <= cnt_ref >= REF_NUM;
                end else cnt_ph <= cnt_ph + 1'b1;
                default: begin
                    state      <= IDLE;
                    cnt_ref    <= '0;
                    aref_end_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_aref_ctrl.sv
// tb_sdram_aref_ctrl: directed checks of request timing and the refresh command sequence
module tb_sdram_aref_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rst_n, init_end, aref_en;
    logic        req, done;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    int          n_chk = 0, n_pass = 0;
    int          bad_req, bad_cmd, n_pre, n_ref, n_end;

    sdram_aref_ctrl dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_end_i(init_end), .aref_en_i(aref_en),
        .aref_req_o(req), .aref_end_o(done), .aref_cmd_o(cmd), .aref_ba_o(ba), .aref_addr_o(addr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // entered in cycle 1 (first cycle after the grant edge); leaves in cycle 21
    task automatic check_seq(input int drop_at);
        check("pre_cmd", cmd, 32'h2);
        check("pre_addr", addr, 32'h0400);
        check("req_clr", req, 0);
        for (int c = 2; c <= 20; c++) begin
            if (c - 1 == drop_at) init_end = 1'b0;
            tick(1);
            check($sformatf("cmd_c%0d", c), cmd, (c == 4 || c == 12) ? 32'h1 : 32'h7);
            check($sformatf("end_c%0d", c), done, c == 20);
        end
        check("seq_addr", addr, 32'h1fff);
        check("seq_req", req, 0);
        tick(1);
        check("end_drop", done, 0);
        check("cmd_idle", cmd, 32'h7);
    endtask

    initial begin
        sys_rst_n = 1'b0; init_end = 1'b0; aref_en = 1'b0;
        tick(2);
        check("rst_cmd", cmd, 32'h7);
        check("rst_ba", ba, 32'h3);
        check("rst_addr", addr, 32'h1fff);
        check("rst_req", req, 0);
        check("rst_end", done, 0);

        sys_rst_n = 1'b1;
        bad_req = 0; bad_cmd = 0;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (req) bad_req++;
            if (cmd != 4'b0111) bad_cmd++;
        end
        check("noinit_req", bad_req, 0);
        check("noinit_cmd", bad_cmd, 0);

        init_end = 1'b1;
        bad_req = 0;
        for (int i = 1; i < 750; i++) begin
            tick(1);
            if (req) bad_req++;
        end
        check("req_early", bad_req, 0);
        tick(1);
        check("req_e750", req, 1);
        bad_req = 0;
        for (int i = 0; i < 750; i++) begin
            tick(1);
            if (!req) bad_req++;
        end
        check("req_hold", bad_req, 0);

        aref_en = 1'b1;
        tick(1);
        aref_en = 1'b0;
        check_seq(0);

        aref_en = 1'b1;
        n_pre = 0; n_ref = 0; n_end = 0;
        for (int i = 0; i < 1505; i++) begin
            tick(1);
            if (cmd == 4'b0010) n_pre++;
            if (cmd == 4'b0001) n_ref++;
            if (done) n_end++;
        end
        aref_en = 1'b0;
        check("hold_pre", n_pre, 2);
        check("hold_ref", n_ref, 4);
        check("hold_end", n_end, 2);

        for (int i = 0; i < 800 && !req; i++) tick(1);
        check("req_rise2", req, 1);
        aref_en = 1'b1;
        tick(1);
        aref_en = 1'b0;
        check("abort_pre", cmd, 32'h2);
        tick(7);
        sys_rst_n = 1'b0;
        tick(1);
        check("abort_cmd", cmd, 32'h7);
        check("abort_addr", addr, 32'h1fff);
        check("abort_ba", ba, 32'h3);
        check("abort_end", done, 0);
        check("abort_req", req, 0);
        sys_rst_n = 1'b1;
        bad_req = 0; bad_cmd = 0; n_end = 0;
        for (int i = 1; i < 750; i++) begin
            tick(1);
            if (req) bad_req++;
            if (cmd != 4'b0111) bad_cmd++;
            if (done) n_end++;
        end
        check("post_rst_req", bad_req, 0);
        check("post_rst_cmd", bad_cmd, 0);
        check("post_rst_end", n_end, 0);
        tick(1);
        check("post_rst_e750", req, 1);

        aref_en = 1'b1;
        tick(1);
        aref_en = 1'b0;
        check_seq(5);
        bad_req = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1);
            if (req) bad_req++;
        end
        check("drop_req", bad_req, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
